// File: rtl/mem_wb_elastic_stage_if.sv
// Handshake and payload bundle for an elastic pipeline-stage boundary.
// The slave modport is the stage's view and the master modport is its environment's view.
interface mem_wb_elastic_stage_if #(
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned DATA_W = 69
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/mem_wb_elastic_stage.sv
// Elastic pipeline register with a 2-entry skid buffer, a registered upstream ready and flush.
// Control bits are zero whenever the stage holds no valid entry, so a bubble never acts downstream.
module mem_wb_elastic_stage #(
  parameter int unsigned        CTRL_W     = 2,
  parameter int unsigned        DATA_W     = 69,
  parameter logic [DATA_W-1:0]  RESET_DATA = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  mem_wb_elastic_stage_if.slave         bus,
  output logic [1:0]                    level
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [1:0]        level_q;

  // Main holds the oldest entry; skid holds the younger one only while FULL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= RESET_DATA;
      skid_ctrl_q <= '0;
      skid_data_q <= RESET_DATA;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      level_q     <= 2'd0;
    end else if (flush) begin
      // out_data is intentionally left untouched
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      level_q     <= 2'd0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (bus.in_valid) begin
            main_ctrl_q <= bus.in_ctrl;
            main_data_q <= bus.in_data;
            out_valid_q <= 1'b1;
            level_q     <= 2'd1;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (bus.out_ready && bus.in_valid) begin
            main_ctrl_q <= bus.in_ctrl;
            main_data_q <= bus.in_data;
          end else if (bus.out_ready) begin
            main_ctrl_q <= '0;
            out_valid_q <= 1'b0;
            level_q     <= 2'd0;
            state_q     <= EMPTY;
          end else if (bus.in_valid) begin
            skid_ctrl_q <= bus.in_ctrl;
            skid_data_q <= bus.in_data;
            in_ready_q  <= 1'b0;
            level_q     <= 2'd2;
            state_q     <= FULL;
          end
        end
        FULL: begin
          if (bus.out_ready) begin
            main_ctrl_q <= skid_ctrl_q;
            main_data_q <= skid_data_q;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
            level_q     <= 2'd1;
            state_q     <= ONE;
          end
        end
        default: begin
          state_q     <= EMPTY;
          main_ctrl_q <= '0;
          skid_ctrl_q <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          level_q     <= 2'd0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ctrl  = main_ctrl_q;
  assign bus.out_data  = main_data_q;
  assign level         = level_q;

endmodule

// File: tb/tb_mem_wb_elastic_stage.sv
// Randomized and directed bench for mem_wb_elastic_stage against a 2-deep FIFO reference model.
module tb_mem_wb_elastic_stage;
  localparam int unsigned       CTRL_W     = 2;
  localparam int unsigned       DATA_W     = 69;
  localparam logic [DATA_W-1:0] RESET_DATA = 69'h0ABC;

  typedef struct {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [1:0] level;

  mem_wb_elastic_stage_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) bus ();

  mem_wb_elastic_stage #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .RESET_DATA(RESET_DATA)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t              q[$];
  logic [DATA_W-1:0] last_d;
  int                n_cmp;
  int                n_bad;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Model: held entries are a FIFO of at most two; out_data shows the latest head ever held.
  task automatic model_update(input logic r, input logic f, input logic iv,
                              input logic [CTRL_W-1:0] ic, input logic [DATA_W-1:0] id,
                              input logic ordy);
    int sz;
    ent_t e;
    sz = q.size();
    if (r) begin
      q.delete();
      last_d = RESET_DATA;
    end else if (f) begin
      q.delete();
    end else begin
      if (sz > 0 && ordy) void'(q.pop_front());
      if (iv && sz < 2) begin
        e.c = ic;
        e.d = id;
        q.push_back(e);
      end
      if (q.size() > 0) last_d = q[0].d;
    end
  endtask

  task automatic check_all();
    logic exp_v;
    logic [CTRL_W-1:0] exp_c;
    exp_v = (q.size() != 0);
    exp_c = exp_v ? q[0].c : '0;
    check_eq("out_valid", 128'(bus.out_valid), 128'(exp_v));
    check_eq("out_ctrl",  128'(bus.out_ctrl),  128'(exp_c));
    check_eq("out_data",  128'(bus.out_data),  128'(last_d));
    check_eq("level",     128'(level),         128'(q.size()));
    check_eq("in_ready",  128'(bus.in_ready),  128'(q.size() < 2));
  endtask

  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [CTRL_W-1:0] ic, input logic [DATA_W-1:0] id,
                      input logic ordy);
    rst          = r;
    flush        = f;
    bus.in_valid = iv;
    bus.in_ctrl  = ic;
    bus.in_data  = id;
    bus.out_ready = ordy;
    @(posedge clk);
    model_update(r, f, iv, ic, id, ordy);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    n_cmp  = 0;
    n_bad  = 0;
    last_d = RESET_DATA;
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_ctrl = '0; bus.in_data = '0; bus.out_ready = 1'b0;
    @(negedge clk);

    // Reset with an input presented: nothing may load
    step(1'b1, 1'b0, 1'b1, 2'b11, 69'h55, 1'b1);
    step(1'b1, 1'b0, 1'b1, 2'b11, 69'h55, 1'b1);
    check_eq("rst_out_data", 128'(bus.out_data), 128'(RESET_DATA));

    // Streaming at full throughput
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 2'b01, DATA_W'(i), 1'b1);
      check_eq("stream_data", 128'(bus.out_data), 128'(i));
      check_eq("stream_level", 128'(level), 128'(1));
    end
    step(1'b0, 1'b0, 1'b0, 2'b00, '0, 1'b1);

    // Backpressure into the skid, then drain
    step(1'b0, 1'b0, 1'b1, 2'b01, 69'h11, 1'b1);
    step(1'b0, 1'b0, 1'b1, 2'b10, 69'h22, 1'b0);
    check_eq("skid_level", 128'(level), 128'(2));
    check_eq("skid_hold", 128'(bus.out_data), 128'(69'h11));
    step(1'b0, 1'b0, 1'b1, 2'b11, 69'h99, 1'b0);
    check_eq("skid_ignore", 128'(bus.out_data), 128'(69'h11));
    step(1'b0, 1'b0, 1'b0, 2'b00, '0, 1'b1);
    check_eq("drain_second", 128'(bus.out_data), 128'(69'h22));
    step(1'b0, 1'b0, 1'b0, 2'b00, '0, 1'b1);

    // Flush while FULL with a live input
    step(1'b0, 1'b0, 1'b1, 2'b01, 69'h11, 1'b1);
    step(1'b0, 1'b0, 1'b1, 2'b01, 69'h22, 1'b0);
    step(1'b0, 1'b1, 1'b1, 2'b11, 69'h33, 1'b0);
    check_eq("flush_level", 128'(level), 128'(0));
    step(1'b0, 1'b0, 1'b0, 2'b00, '0, 1'b1);
    check_eq("flush_no33", 128'(bus.out_valid), 128'(0));

    // Bubble after a ctrl=11 entry drains
    step(1'b0, 1'b0, 1'b1, 2'b11, 69'h1F_0000_0000_0000_0044, 1'b1);
    step(1'b0, 1'b0, 1'b0, 2'b00, '0, 1'b1);
    check_eq("bubble_ctrl", 128'(bus.out_ctrl), 128'(0));
    check_eq("bubble_data", 128'(bus.out_data), 128'(69'h1F_0000_0000_0000_0044));

    // Random traffic with flush and rare reset
    for (int i = 0; i < 10000; i++) begin
      rd = DATA_W'({$urandom, $urandom, $urandom});
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 1) == 1), CTRL_W'($urandom), rd,
           ($urandom_range(0, 9) < 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
